frog_button_conditioner: RTL and testbench

//  Upstream of frogger: turns four raw, bouncy, asynchronous active-low push-buttons into clean move strobes.
//  - Each button is synchronised, debounced and edge-detected, with optional auto-repeat while held.
//  - Each strobe is active-low, exactly one cycle wide, and wires straight to frogger up/down/left/right.
//  - One accepted press therefore moves the frog exactly one grid step, not one step per clock.

---
 rtl/frog_button_conditioner.sv | 89 ++++++++
 tb/tb_frog_button_conditioner.sv | 117 +++++++++++
 2 files changed

// File: rtl/frog_button_conditioner.sv
// frog_button_conditioner: synchronise, debounce and edge-detect four active-low buttons into one-cycle move strobes with auto-repeat
module frog_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] held,
  output logic       any_press
);
  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
  logic [3:0] raw, s1, s2, deb, stb, np;
  logic [19:0] dcnt [4];
  assign raw  = {btn_up_n, btn_down_n, btn_left_n, btn_right_n};
  assign held = deb;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
      deb <= '0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 4; i++)
        if (!s2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == 20'(DEBOUNCE_CYCLES - 1)) begin
          dcnt[i] <= '0;
          deb[i] <= !deb[i];
        end else dcnt[i] <= dcnt[i] + 1'b1;
    end
  end
  for (genvar b = 0; b < 4; b++) begin : g_btn
    state_t st, st_nx;
    logic [25:0] rc, rc_nx;
    logic go;
    always_comb begin
      st_nx = st;
      rc_nx = (REPEAT_EN != 0) ? rc + 1'b1 : '0;
      go = 1'b0;
      if (!deb[b]) begin
        st_nx = IDLE;
        rc_nx = '0;
      end else if (st == IDLE) begin
        st_nx = PRESSED;
        rc_nx = '0;
        go = 1'b1;
      end else if (REPEAT_EN != 0 && rc == (st == PRESSED ? 26'(REPEAT_DELAY - 1) : 26'(REPEAT_PERIOD - 1))) begin
        st_nx = REPEAT;
        rc_nx = '0;
        go = 1'b1;
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        st <= IDLE;
        rc <= '0;
      end else begin
        st <= st_nx;
        rc <= rc_nx;
      end
    end
    assign stb[b] = go;
    assign np[b]  = deb[b] && st == IDLE;
  end
  // opposing strobes in the same cycle cancel each other
  always_ff @(posedge clk) begin
    if (reset) begin
      {up, down, left, right} <= '1;
      any_press <= 1'b0;
    end else begin
      up <= !(stb[3] && !stb[2]);
      down <= !(stb[2] && !stb[3]);
      left <= !(stb[1] && !stb[0]);
      right <= !(stb[0] && !stb[1]);
      any_press <= |np;
    end
  end
endmodule

// File: tb/tb_frog_button_conditioner.sv
// tb_frog_button_conditioner: scoreboard bench comparing two DUTs (repeat on/off) against a cycle-indexed reference model
module tb_frog_button_conditioner;
  localparam int D = 4, DLY = 10, PER = 5;
  logic clk = 0, reset = 1;
  logic [3:0] btn_n = '1;
  logic up_a, down_a, left_a, right_a, ap_a, up_b, down_b, left_b, right_b, ap_b;
  logic [3:0] held_a, held_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  frog_button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_a (
    .clk(clk), .reset(reset), .btn_up_n(btn_n[3]), .btn_down_n(btn_n[2]), .btn_left_n(btn_n[1]),
    .btn_right_n(btn_n[0]), .up(up_a), .down(down_a), .left(left_a), .right(right_a),
    .held(held_a), .any_press(ap_a));
  frog_button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_b (
    .clk(clk), .reset(reset), .btn_up_n(btn_n[3]), .btn_down_n(btn_n[2]), .btn_left_n(btn_n[1]),
    .btn_right_n(btn_n[0]), .up(up_b), .down(down_b), .left(left_b), .right(right_b),
    .held(held_b), .any_press(ap_b));

  logic [8:0] qa [$];
  logic [8:0] qb [$];
  bit d1 [4], sy [4], deb [4];
  bit [D-1:0] hist [4];
  int tp [4];
  int cyc = 0;
  bit seen = 0;

  // model: synced = raw delayed two edges; level accepted after D consecutive differing samples;
  // strobes at press+1, then press+1+DLY+n*PER while held
  always @(posedge clk) begin
    bit sa [4], sb [4], newp [4], old;
    int k;
    if (reset) begin
      seen = 1;
      for (int b = 0; b < 4; b++) begin
        d1[b] = 0; sy[b] = 0; deb[b] = 0; hist[b] = '0; tp[b] = -1000;
      end
      qa.push_back(9'b1111_0000_0);
      qb.push_back(9'b1111_0000_0);
    end else if (seen) begin
      cyc++;
      for (int b = 0; b < 4; b++) begin
        old = deb[b];
        hist[b] = {hist[b][D-2:0], sy[b]};
        if (hist[b] == {D{!deb[b]}}) deb[b] = !deb[b];
        sy[b] = d1[b];
        d1[b] = !btn_n[b];
        k = cyc - tp[b] - 1;
        newp[b] = old && k == 0;
        sa[b] = old && (k == 0 || (k >= DLY && (k - DLY) % PER == 0));
        sb[b] = newp[b];
        if (deb[b] && !old) tp[b] = cyc;
      end
      qa.push_back({!(sa[3] && !sa[2]), !(sa[2] && !sa[3]), !(sa[1] && !sa[0]), !(sa[0] && !sa[1]),
                    deb[3], deb[2], deb[1], deb[0], newp[3] || newp[2] || newp[1] || newp[0]});
      qb.push_back({!(sb[3] && !sb[2]), !(sb[2] && !sb[3]), !(sb[1] && !sb[0]), !(sb[0] && !sb[1]),
                    deb[3], deb[2], deb[1], deb[0], newp[3] || newp[2] || newp[1] || newp[0]});
    end
  end

  always @(posedge clk) begin
    logic [8:0] e, g;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      g = {up_a, down_a, left_a, right_a, held_a, ap_a};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rep_on cyc %0d got %b required %b", cyc, g, e);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      g = {up_b, down_b, left_b, right_b, held_b, ap_b};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rep_off cyc %0d got %b required %b", cyc, g, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [5:0] bounce;
    bounce = 6'b101010;
    @(negedge clk);
    idle(2);
    reset = 0;
    idle(3);
    btn_n[3] = 0; idle(8); btn_n[3] = 1; idle(20);
    for (int i = 5; i >= 0; i--) begin
      btn_n[1] = bounce[i];
      idle(1);
    end
    idle(15); btn_n[1] = 1; idle(15);
    btn_n[0] = 0; idle(40); btn_n[0] = 1; idle(15);
    btn_n[3] = 0; btn_n[2] = 0; idle(20); btn_n[1] = 0; idle(20); btn_n = '1; idle(15);
    btn_n[2] = 0; idle(12); reset = 1; idle(1); reset = 0; idle(30); btn_n[2] = 1; idle(15);
    btn_n[0] = 0; idle(2); btn_n[0] = 1; idle(15);
    repeat (40) begin
      btn_n = 4'($urandom);
      reset = ($urandom_range(0, 30) == 0);
      idle(1);
      reset = 0;
      idle($urandom_range(1, 20));
    end
    btn_n = '1;
    idle(30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
